mips_cycle_ctrl: RTL

//  Multicycle sequencer for the MIPS core: drives the FETCH/EXEC1/EXEC2 state consumed by the IR and datapath.

---
 rtl/mips_cycle_ctrl_if.sv | 29 ++
 rtl/mips_cycle_ctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/mips_cycle_ctrl_if.sv
// Bus/strobe bundle between the MIPS cycle controller and the memory/datapath side.
// slave = controller side, master = bus/datapath side driving the status inputs.
interface mips_cycle_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             waitrequest_i;
  logic             mem_access_i;
  logic             halt_req_i;
  logic [1:0]       state_o;
  logic             mem_read_o;
  logic             ir_wen_o;
  logic             pc_wen_o;
  logic             active_o;
  logic             fault_o;
  logic [CNT_W-1:0] instr_count_o;
  logic [CNT_W-1:0] stall_count_o;

  modport slave (
    input  waitrequest_i, mem_access_i, halt_req_i,
    output state_o, mem_read_o, ir_wen_o, pc_wen_o, active_o, fault_o,
           instr_count_o, stall_count_o
  );

  modport master (
    output waitrequest_i, mem_access_i, halt_req_i,
    input  state_o, mem_read_o, ir_wen_o, pc_wen_o, active_o, fault_o,
           instr_count_o, stall_count_o
  );
endinterface

// File: rtl/mips_cycle_ctrl.sv
// Multicycle FETCH/EXEC1/EXEC2 sequencer with waitrequest stalls, halt and bus timeout.
// Optional perf counters are built when CTRL_PERF_CNT_EN is defined.
module mips_cycle_ctrl #(
  parameter int unsigned MAX_WAIT = 255,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 reset_i,
  mips_cycle_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_EXEC1  = 2'd1,
    S_EXEC2  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  localparam int unsigned     WC_W   = (MAX_WAIT == 0) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WC_W-1:0] WC_MAX = '1;

  state_t          state_q, state_d;
  logic            acc_q, acc_d;
  logic            fault_q, fault_d;
  logic [WC_W-1:0] wait_q, wait_d;

  logic mem_read_c, ir_wen_c, pc_wen_c, stalled_c, timeout_c;

  // State, access flag, fault and stall-run registers
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_FETCH;
      acc_q   <= 1'b0;
      fault_q <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fault_q <= fault_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    fault_d    = fault_q;
    wait_d     = '0;
    mem_read_c = 1'b0;
    ir_wen_c   = 1'b0;
    pc_wen_c   = 1'b0;
    stalled_c  = 1'b0;
    timeout_c  = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read_c = 1'b1;
        if (!bus.waitrequest_i) state_d = S_EXEC1;
      end
      S_EXEC1: begin
        ir_wen_c = 1'b1;
        acc_d    = bus.mem_access_i;
        state_d  = S_EXEC2;
      end
      S_EXEC2: begin
        mem_read_c = acc_q;
        if (!acc_q || !bus.waitrequest_i) begin
          pc_wen_c = 1'b1;
          state_d  = bus.halt_req_i ? S_HALTED : S_FETCH;
        end
      end
      default: ;
    endcase

    stalled_c = mem_read_c & bus.waitrequest_i;
    if (stalled_c) begin
      wait_d = (wait_q == WC_MAX) ? wait_q : wait_q + WC_W'(1);
    end

    // The MAX_WAIT-th consecutive stalled cycle is the timeout cycle
    timeout_c = stalled_c && (MAX_WAIT != 0) && ((32'(wait_q) + 32'd1) >= MAX_WAIT);
    if (timeout_c) begin
      state_d  = S_HALTED;
      fault_d  = 1'b1;
      pc_wen_c = 1'b0;
      ir_wen_c = 1'b0;
    end
  end

  assign bus.state_o    = state_q;
  assign bus.mem_read_o = mem_read_c & ~reset_i;
  assign bus.ir_wen_o   = ir_wen_c & ~reset_i;
  assign bus.pc_wen_o   = pc_wen_c & ~reset_i;
  assign bus.active_o   = (state_q != S_HALTED);
  assign bus.fault_o    = fault_q;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] instr_cnt_q, stall_cnt_q;

  // Retired-instruction and stall-cycle counters, wrapping
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      instr_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (pc_wen_c)  instr_cnt_q <= instr_cnt_q + CNT_W'(1);
      if (stalled_c) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.instr_count_o = instr_cnt_q;
  assign bus.stall_count_o = stall_cnt_q;
`else
  assign bus.instr_count_o = CNT_W'(0);
  assign bus.stall_count_o = CNT_W'(0);
`endif

endmodule
